// File: rtl/change_sequencer.sv
// change_sequencer: greedy coin-change controller for the coin dispenser.
// Accepts an amount in cents and tracks an on-board coin inventory. It issues
// one-hot single-coin requests (largest denomination first) over a req/ack
// handshake, then reports completion and any unpaid residue.
module change_sequencer #(
    parameter int AMT_W = 9,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [AMT_W-1:0]   req_amount,
    output logic               req_ready,
    input  logic               inv_load,
    input  logic [5*CNT_W-1:0] inv_data,
    output logic [5*CNT_W-1:0] inv_count,
    output logic [4:0]         coin_req,
    input  logic               coin_ack,
    output logic               busy,
    output logic               done,
    output logic               short,
    output logic [AMT_W-1:0]   remaining
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_FINISH   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] inv_r [5];
    logic [AMT_W-1:0] remaining_r;
    logic             short_r;
    logic [4:0]       coin_req_r;
    logic [4:0]       avail_s;
    logic [4:0]       sel_s;

    // Face value of denomination index 0..4 = P,N,D,Q,B.
    function automatic logic [AMT_W-1:0] den_value(input int idx);
        logic [AMT_W-1:0] val;
        case (idx)
            0:       val = AMT_W'(7'd1);
            1:       val = AMT_W'(7'd5);
            2:       val = AMT_W'(7'd10);
            3:       val = AMT_W'(7'd25);
            4:       val = AMT_W'(7'd100);
            default: val = {AMT_W{1'b0}};
        endcase
        return val;
    endfunction

    // Face value of a one-hot coin vector (zero vector gives zero).
    function automatic logic [AMT_W-1:0] coin_value(input logic [4:0] onehot);
        logic [AMT_W-1:0] val;
        val = {AMT_W{1'b0}};
        for (int i = 0; i < 5; i++) begin
            if (onehot[i]) begin
                val = val | den_value(i);
            end else begin
                val = val;
            end
        end
        return val;
    endfunction

    // A denomination is usable if it is stocked and does not overpay.
    always_comb begin
        avail_s = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            avail_s[i] = (inv_r[i] != {CNT_W{1'b0}}) && (den_value(i) <= remaining_r);
        end
    end

    // Greedy pick: highest usable denomination wins.
    always_comb begin
        sel_s = 5'b00000;
        if (avail_s[4]) begin
            sel_s = 5'b10000;
        end else if (avail_s[3]) begin
            sel_s = 5'b01000;
        end else if (avail_s[2]) begin
            sel_s = 5'b00100;
        end else if (avail_s[1]) begin
            sel_s = 5'b00010;
        end else if (avail_s[0]) begin
            sel_s = 5'b00001;
        end else begin
            sel_s = 5'b00000;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    next_state_s = ST_SELECT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (sel_s != 5'b00000) begin
                    next_state_s = ST_DISPENSE;
                end else begin
                    next_state_s = ST_FINISH;
                end
            end
            ST_DISPENSE: begin
                if (coin_ack) begin
                    next_state_s = ST_SELECT;
                end else begin
                    next_state_s = ST_DISPENSE;
                end
            end
            ST_FINISH: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Amount owed, shortage flag and the registered coin request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_r <= {AMT_W{1'b0}};
            short_r     <= 1'b0;
            coin_req_r  <= 5'b00000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        remaining_r <= req_amount;
                        short_r     <= 1'b0;
                    end else begin
                        remaining_r <= remaining_r;
                    end
                end
                ST_SELECT: begin
                    if (sel_s != 5'b00000) begin
                        coin_req_r <= sel_s;
                    end else begin
                        // Nothing usable: any residue left is a shortfall.
                        short_r <= (remaining_r != {AMT_W{1'b0}});
                    end
                end
                ST_DISPENSE: begin
                    if (coin_ack) begin
                        remaining_r <= remaining_r - coin_value(coin_req_r);
                        coin_req_r  <= 5'b00000;
                    end else begin
                        coin_req_r  <= coin_req_r;
                    end
                end
                default: begin
                    coin_req_r <= coin_req_r;
                end
            endcase
        end
    end

    // Inventory: bulk load only while idle, one decrement per acknowledged coin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) begin
                inv_r[i] <= {CNT_W{1'b0}};
            end
        end else if ((state_r == ST_IDLE) && inv_load) begin
            for (int i = 0; i < 5; i++) begin
                inv_r[i] <= inv_data[i*CNT_W +: CNT_W];
            end
        end else if ((state_r == ST_DISPENSE) && coin_ack) begin
            for (int i = 0; i < 5; i++) begin
                if (coin_req_r[i]) begin
                    inv_r[i] <= inv_r[i] - CNT_W'(1'b1);
                end else begin
                    inv_r[i] <= inv_r[i];
                end
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                inv_r[i] <= inv_r[i];
            end
        end
    end

    // Output decode from the state and data registers.
    always_comb begin
        req_ready = (state_r == ST_IDLE);
        busy      = (state_r != ST_IDLE);
        done      = (state_r == ST_FINISH);
        coin_req  = coin_req_r;
        short     = short_r;
        remaining = remaining_r;
        inv_count = {5*CNT_W{1'b0}};
        for (int i = 0; i < 5; i++) begin
            inv_count[i*CNT_W +: CNT_W] = inv_r[i];
        end
    end

endmodule
